// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: states, ALU ops,
// instruction classes, opcode/funct constants and mux-select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HOLD = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    C_NOP, C_R, C_SHIFT, C_JR, C_JALR, C_J, C_JAL, C_BEQ, C_LW, C_SW, C_IALU
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [1:0] REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_A = 2'b01, SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_REG = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: opcode/funct to instruction class, execute-stage
// ALU operation and immediate-extension controls.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output alu_op_e    alu_op,
  output logic       ext_op,
  output logic       lu_op
);

  always_comb begin
    iclass = C_NOP;
    alu_op = ALU_ADD;
    ext_op = 1'b1;
    lu_op  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:          begin iclass = C_SHIFT; alu_op = ALU_SLL;  end
          FN_SRL:          begin iclass = C_SHIFT; alu_op = ALU_SRL;  end
          FN_SRA:          begin iclass = C_SHIFT; alu_op = ALU_SRA;  end
          FN_JR:           iclass = C_JR;
          FN_JALR:         iclass = C_JALR;
          FN_ADD, FN_ADDU: begin iclass = C_R; alu_op = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin iclass = C_R; alu_op = ALU_SUB;  end
          FN_AND:          begin iclass = C_R; alu_op = ALU_AND;  end
          FN_OR:           begin iclass = C_R; alu_op = ALU_OR;   end
          FN_XOR:          begin iclass = C_R; alu_op = ALU_XOR;  end
          FN_NOR:          begin iclass = C_R; alu_op = ALU_NOR;  end
          FN_SLT:          begin iclass = C_R; alu_op = ALU_SLT;  end
          FN_SLTU:         begin iclass = C_R; alu_op = ALU_SLTU; end
          default:         iclass = C_NOP;
        endcase
      end
      OP_J:              iclass = C_J;
      OP_JAL:            iclass = C_JAL;
      OP_BEQ:            begin iclass = C_BEQ;  alu_op = ALU_SUB;  end
      OP_ADDI, OP_ADDIU: iclass = C_IALU;
      OP_SLTI:           begin iclass = C_IALU; alu_op = ALU_SLT;  end
      OP_SLTIU:          begin iclass = C_IALU; alu_op = ALU_SLTU; end
      OP_ANDI:           begin iclass = C_IALU; alu_op = ALU_AND; ext_op = 1'b0; end
      OP_ORI:            begin iclass = C_IALU; alu_op = ALU_OR;  ext_op = 1'b0; end
      // lui carries rs=$0, so A + (imm<<16) yields the result with a plain add
      OP_LUI:            begin iclass = C_IALU; lu_op = 1'b1; end
      OP_LW:             iclass = C_LW;
      OP_SW:             iclass = C_SW;
      default:           iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS datapath sequencer. Optional MULTICYCLE_PERF_EN adds cycle_cnt/instr_cnt.
// state | meaning: IF fetch, ID decode/jump, EX execute/branch, MEM load/store, WB writeback, HOLD post-reset wait
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_wr_cond,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        ext_op,
  output logic        lu_op,
  output logic [2:0]  state
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_e     state_q, state_d;
  logic [1:0] hold_cnt;
  iclass_e    iclass;
  alu_op_e    dec_alu_op, alu_op_c;
  logic       dec_ext_op, dec_lu_op;
  logic       zero_unused;

  // zero only qualifies pc_wr_cond inside the datapath
  assign zero_unused = zero;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass),
    .alu_op (dec_alu_op),
    .ext_op (dec_ext_op),
    .lu_op  (dec_lu_op)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_HOLD;
      hold_cnt <= 2'(RESET_PC_HOLD);
    end else begin
      state_q <= state_d;
      if (state_q == S_HOLD && hold_cnt != 2'd0)
        hold_cnt <= hold_cnt - 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_wr_cond = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    alu_op_c   = ALU_ADD;
    pc_source  = PCSRC_ALU;
    ext_op     = 1'b0;
    lu_op      = 1'b0;
    if (state_q != S_HOLD) begin
      ext_op = dec_ext_op;
      lu_op  = dec_lu_op;
    end
    case (state_q)
      S_HOLD: if (hold_cnt == 2'd0) state_d = S_IF;
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = SRCB_IMM_SH2;
        state_d   = S_IF;
        case (iclass)
          C_J:    begin pc_write = 1'b1; pc_source = PCSRC_JUMP; end
          C_JAL: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            reg_write  = 1'b1;
            reg_dst    = REGDST_RA;
            mem_to_reg = M2R_PC;
          end
          C_JR:   begin pc_write = 1'b1; pc_source = PCSRC_REG; end
          C_JALR: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_REG;
            reg_write  = 1'b1;
            reg_dst    = REGDST_RD;
            mem_to_reg = M2R_PC;
          end
          C_NOP:  state_d = S_IF;
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        state_d = S_IF;
        case (iclass)
          C_R, C_SHIFT: begin
            alu_src_a = (iclass == C_SHIFT) ? SRCA_SHAMT : SRCA_A;
            alu_src_b = SRCB_B;
            alu_op_c  = dec_alu_op;
            state_d   = S_WB;
          end
          C_IALU: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
            alu_op_c  = dec_alu_op;
            state_d   = S_WB;
          end
          C_LW, C_SW: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
            state_d   = S_MEM;
          end
          C_BEQ: begin
            alu_src_a  = SRCA_A;
            alu_src_b  = SRCB_B;
            alu_op_c   = ALU_SUB;
            pc_wr_cond = 1'b1;
            pc_source  = PCSRC_ALUOUT;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (iclass == C_LW);
        mem_write = (iclass == C_SW);
        if (mem_ready) state_d = (iclass == C_LW) ? S_WB : S_IF;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (iclass == C_R || iclass == C_SHIFT) ? REGDST_RD : REGDST_RT;
        mem_to_reg = (iclass == C_LW) ? M2R_MDR : M2R_ALU;
        state_d    = S_IF;
      end
      default: state_d = S_HOLD;
    endcase
  end

  assign alu_op = alu_op_c;
  assign state  = state_q;

`ifdef MULTICYCLE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (state_q != S_HOLD) cycle_cnt <= cycle_cnt + 32'd1;
      if (state_d == S_IF && (state_q == S_ID || state_q == S_EX || state_q == S_MEM || state_q == S_WB))
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output sequence and compared every cycle; directed cases pin the model.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  localparam int HOLD_N = 2;
  localparam int K_NOP = 0, K_R = 1, K_SH = 2, K_JR = 3, K_JALR = 4, K_J = 5,
                 K_JAL = 6, K_BEQ = 7, K_LW = 8, K_SW = 9, K_I = 10;

  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, pc_wr_cond, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
  logic [3:0] alu_op;
  logic ext_op, lu_op;
  logic [2:0] state;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl #(.RESET_PC_HOLD(HOLD_N)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_wr_cond(pc_wr_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .ext_op(ext_op), .lu_op(lu_op), .state(state)
`ifdef MULTICYCLE_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcc, iord, mr, mw, irw, rw;
    logic [1:0] rd, m2r, sa, sb;
    logic [3:0] alu;
    logic [1:0] ps;
    logic ext, lu;
    logic [2:0] st;
  } ov_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic rdy;
    logic z;
    ov_t o;
  } ent_t;

  ent_t q[$];
  ov_t obs[$];
  int tests = 0, fails = 0;
  int unsigned m_cyc = 0, m_ins = 0;
  logic [2:0] prev_st = S_HOLD;

  function automatic ov_t actual();
    ov_t a;
    a = {pc_write, pc_wr_cond, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
         mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, ext_op, lu_op, state};
    return a;
  endfunction

  function automatic ov_t base(input logic [5:0] op, input logic [2:0] st);
    ov_t o;
    o = '0;
    o.ext = !(op == OP_ANDI || op == OP_ORI);
    o.lu = (op == OP_LUI);
    o.st = st;
    return o;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                      input logic z, input ov_t o);
    ent_t e;
    e.op = op; e.fn = fn; e.rdy = rdy; e.z = z; e.o = o;
    q.push_back(e);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from fetch to its last cycle.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int kind,
                     input alu_op_e alu, input int w_if, input int w_mem, input logic z);
    ov_t o;
    for (int i = 0; i < w_if; i++) begin
      o = base(op, S_IF); o.mr = 1; o.sb = 2'b01;
      push(op, fn, 1'b0, z, o);
    end
    o = base(op, S_IF); o.mr = 1; o.sb = 2'b01; o.irw = 1; o.pcw = 1;
    push(op, fn, 1'b1, z, o);
    o = base(op, S_ID); o.sb = 2'b11;
    case (kind)
      K_J:    begin o.pcw = 1; o.ps = 2'b10; end
      K_JAL:  begin o.pcw = 1; o.ps = 2'b10; o.rw = 1; o.rd = 2'b10; o.m2r = 2'b10; end
      K_JR:   begin o.pcw = 1; o.ps = 2'b11; end
      K_JALR: begin o.pcw = 1; o.ps = 2'b11; o.rw = 1; o.rd = 2'b01; o.m2r = 2'b10; end
      default: ;
    endcase
    push(op, fn, 1'($urandom_range(0, 1)), z, o);
    if (kind == K_J || kind == K_JAL || kind == K_JR || kind == K_JALR || kind == K_NOP) return;
    o = base(op, S_EX);
    case (kind)
      K_R:        begin o.sa = 2'b01; o.alu = alu; end
      K_SH:       begin o.sa = 2'b10; o.alu = alu; end
      K_I:        begin o.sa = 2'b01; o.sb = 2'b10; o.alu = alu; end
      K_LW, K_SW: begin o.sa = 2'b01; o.sb = 2'b10; o.alu = ALU_ADD; end
      default:    begin o.sa = 2'b01; o.alu = ALU_SUB; o.pcc = 1; o.ps = 2'b01; end
    endcase
    push(op, fn, 1'($urandom_range(0, 1)), z, o);
    if (kind == K_BEQ) return;
    if (kind == K_LW || kind == K_SW) begin
      o = base(op, S_MEM); o.iord = 1; o.mr = (kind == K_LW); o.mw = (kind == K_SW);
      for (int i = 0; i < w_mem; i++) push(op, fn, 1'b0, z, o);
      push(op, fn, 1'b1, z, o);
      if (kind == K_SW) return;
    end
    o = base(op, S_WB); o.rw = 1;
    o.rd = (kind == K_R || kind == K_SH) ? 2'b01 : 2'b00;
    o.m2r = (kind == K_LW) ? 2'b01 : 2'b00;
    push(op, fn, 1'($urandom_range(0, 1)), z, o);
  endtask

  task automatic pick(input int i, output logic [5:0] op, output logic [5:0] fn,
                      output int kind, output alu_op_e alu);
    op = OP_RTYPE; fn = '0; kind = K_NOP; alu = ALU_ADD;
    case (i)
      0:  begin fn = FN_ADD;  kind = K_R; end
      1:  begin fn = FN_SUB;  kind = K_R; alu = ALU_SUB; end
      2:  begin fn = FN_AND;  kind = K_R; alu = ALU_AND; end
      3:  begin fn = FN_OR;   kind = K_R; alu = ALU_OR; end
      4:  begin fn = FN_XOR;  kind = K_R; alu = ALU_XOR; end
      5:  begin fn = FN_NOR;  kind = K_R; alu = ALU_NOR; end
      6:  begin fn = FN_SLT;  kind = K_R; alu = ALU_SLT; end
      7:  begin fn = FN_SLTU; kind = K_R; alu = ALU_SLTU; end
      8:  begin fn = FN_SLL;  kind = K_SH; alu = ALU_SLL; end
      9:  begin fn = FN_SRL;  kind = K_SH; alu = ALU_SRL; end
      10: begin fn = FN_SRA;  kind = K_SH; alu = ALU_SRA; end
      11: begin fn = FN_JR;   kind = K_JR; end
      12: begin fn = FN_JALR; kind = K_JALR; end
      13: begin op = OP_J;     kind = K_J; fn = 6'($urandom); end
      14: begin op = OP_JAL;   kind = K_JAL; end
      15: begin op = OP_BEQ;   kind = K_BEQ; end
      16: begin op = OP_ADDI;  kind = K_I; end
      17: begin op = OP_SLTI;  kind = K_I; alu = ALU_SLT; end
      18: begin op = OP_ANDI;  kind = K_I; alu = ALU_AND; end
      19: begin op = OP_ORI;   kind = K_I; alu = ALU_OR; end
      20: begin op = OP_LUI;   kind = K_I; end
      21: begin op = OP_LW;    kind = K_LW; end
      22: begin op = OP_SW;    kind = K_SW; end
      23: begin op = 6'h3f;    kind = K_NOP; end
      24: begin fn = 6'h3f;    kind = K_NOP; end
      25: begin op = OP_SLTIU; kind = K_I; alu = ALU_SLTU; end
      26: begin fn = FN_ADDU;  kind = K_R; end
      27: begin fn = FN_SUBU;  kind = K_R; alu = ALU_SUB; end
      default: begin op = OP_ADDIU; kind = K_I; end
    endcase
  endtask

  task automatic step();
    ent_t e;
    ov_t a;
    e = q.pop_front();
    @(negedge clk);
    opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z;
    #1;
    a = actual();
    tests++;
    if (a !== e.o) begin
      fails++;
      $display("FAIL outputs (state %0d): got %h expected %h", e.o.st, a, e.o);
    end
    obs.push_back(a);
`ifdef MULTICYCLE_PERF_EN
    if (e.o.st == S_IF && (prev_st == S_ID || prev_st == S_EX || prev_st == S_MEM || prev_st == S_WB))
      m_ins++;
    tests++;
    if (cycle_cnt !== m_cyc || instr_cnt !== m_ins) begin
      fails++;
      $display("FAIL perf_counters: got %0d/%0d expected %0d/%0d", cycle_cnt, instr_cnt, m_cyc, m_ins);
    end
    if (e.o.st != S_HOLD) m_cyc++;
`endif
    prev_st = e.o.st;
  endtask

  task automatic run_all();
    while (q.size() > 0) step();
  endtask

  task automatic check_reset(input string name);
    ov_t r;
    r = '0; r.st = S_HOLD;
    tests++;
    if (actual() !== r) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, actual(), r);
    end
`ifdef MULTICYCLE_PERF_EN
    check_int({name, "_perf"}, int'(cycle_cnt) + int'(instr_cnt), 0);
`endif
  endtask

  task automatic release_reset();
    ov_t r;
    q.delete(); m_cyc = 0; m_ins = 0; prev_st = S_HOLD;
    @(posedge clk); #2 reset = 1'b0;
    r = '0; r.st = S_HOLD;
    for (int i = 0; i <= HOLD_N; i++) push(6'd0, 6'd0, 1'($urandom_range(0, 1)), 1'b0, r);
    run_all();
  endtask

  int cnt_a, cnt_b;
  logic [5:0] r_op, r_fn;
  int r_kind;
  alu_op_e r_alu;

  initial begin
    @(negedge clk); #1;
    check_reset("reset_state");
    release_reset();

    // lw, no waits: IF ID EX MEM WB, reg_write only in WB with MDR source
    gen(OP_LW, 6'd0, K_LW, ALU_ADD, 0, 0, 1'b0);
    check_int("lw_len", q.size(), 5);
    obs.delete(); run_all();
    for (int i = 0; i < 5; i++) check_int("lw_state", int'(obs[i].st), i);
    cnt_a = 0;
    foreach (obs[i]) if (obs[i].rw) cnt_a++;
    check_int("lw_rw_cycles", cnt_a, 1);
    check_int("lw_m2r", int'(obs[4].m2r), 1);

    // beq with zero=1 then zero=0: 3 cycles each, pc_wr_cond in EX
    for (int z = 1; z >= 0; z--) begin
      gen(OP_BEQ, 6'd0, K_BEQ, ALU_SUB, 0, 0, 1'(z));
      check_int("beq_len", q.size(), 3);
      obs.delete(); run_all();
      check_int("beq_pcc_ex", int'(obs[2].pcc) + 2 * int'(obs[2].st == S_EX), 3);
    end

    // sw with mem_ready low for 2 cycles in MEM
    gen(OP_SW, 6'd0, K_SW, ALU_ADD, 0, 2, 1'b0);
    check_int("sw_len", q.size(), 6);
    obs.delete(); run_all();
    cnt_a = 0; cnt_b = 0;
    foreach (obs[i]) begin
      if (obs[i].st == S_MEM) cnt_a++;
      if (obs[i].mw) cnt_b++;
    end
    check_int("sw_mem_cycles", cnt_a, 3);
    check_int("sw_mw_cycles", cnt_b, 3);

    // jal: decode cycle does the jump and the link write
    gen(OP_JAL, 6'd0, K_JAL, ALU_ADD, 0, 0, 1'b0);
    check_int("jal_len", q.size(), 2);
    obs.delete(); run_all();
    check_int("jal_id", {obs[1].pcw, obs[1].ps, obs[1].rw, obs[1].rd}, 6'b1_10_1_10);

    // next fetch follows; then reset lands in S_MEM of a stalled sw
    gen(OP_SW, 6'd0, K_SW, ALU_ADD, 0, 4, 1'b0);
    repeat (4) step();
    check_int("pre_reset_state", int'(state), int'(S_MEM));
    #1 reset = 1'b1;
    #1 check_reset("reset_mid_sw");
    release_reset();

    // 10 back-to-back adds with no waits
    for (int i = 0; i < 10; i++) gen(OP_RTYPE, FN_ADD, K_R, ALU_ADD, 0, 0, 1'b0);
    check_int("add10_len", q.size(), 40);
    run_all();
    gen(OP_RTYPE, FN_ADD, K_R, ALU_ADD, 0, 0, 1'b0);
    step();
`ifdef MULTICYCLE_PERF_EN
    check_int("perf_cycle_40", int'(cycle_cnt), 40);
    check_int("perf_instr_10", int'(instr_cnt), 10);
`endif
    run_all();

    // randomized instruction mix with random memory waits
    for (int n = 0; n < 300; n++) begin
      pick($urandom_range(0, 28), r_op, r_fn, r_kind, r_alu);
      gen(r_op, r_fn, r_kind, r_alu, $urandom_range(0, 2), $urandom_range(0, 2),
          1'($urandom_range(0, 1)));
      run_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
